// File: rtl/mem_fault_sequencer.sv
// mem_fault_sequencer: privilege mode owner and memory-protection trap sequencer
module mem_fault_sequencer #(
  parameter logic [15:0] TRAP_VECTOR  = 16'h0010,
  parameter logic [1:0]  KERNEL_MODE  = 2'b10,
  parameter logic [1:0]  RESET_MODE   = 2'b10,
  parameter int unsigned FLUSH_CYCLES = 2
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        illegal_pc,
  input  logic        illegal_mem,
  input  logic [15:0] cur_pc,
  input  logic [15:0] fault_addr,
  input  logic        eret,
  input  logic        mode_we,
  input  logic [1:0]  mode_wdata,
  output logic [1:0]  mode,
  output logic        stall,
  output logic        flush,
  output logic        pc_redirect,
  output logic [15:0] redirect_pc,
  output logic [15:0] epc,
  output logic [1:0]  cause,
  output logic [15:0] bad_addr,
  output logic        trap_active,
  output logic        halted
);
  typedef enum logic [2:0] {IDLE, FLUSH, REDIRECT, HANDLER, RETURN, HALT} state_t;
  localparam logic [3:0] LAST = 4'(FLUSH_CYCLES);
  state_t      state;
  logic [1:0]  saved_mode;
  logic [3:0]  cnt;
  logic        fault;
  assign fault = illegal_pc | illegal_mem;
  // Trap FSM: every output is set on the edge that enters the state it belongs to
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode        <= RESET_MODE;
      saved_mode  <= RESET_MODE;
      cnt         <= '0;
      stall       <= 1'b0;
      flush       <= 1'b0;
      pc_redirect <= 1'b0;
      redirect_pc <= '0;
      epc         <= '0;
      cause       <= 2'b00;
      bad_addr    <= '0;
      trap_active <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fault) begin
            state      <= FLUSH;
            stall      <= 1'b1;
            flush      <= 1'b1;
            cnt        <= 4'd1;
            epc        <= cur_pc;
            saved_mode <= mode;
            cause      <= illegal_pc ? 2'b01 : 2'b10;
            if (!illegal_pc) bad_addr <= fault_addr;
          end else if (mode_we) mode <= mode_wdata;
        end
        FLUSH: begin
          if (cnt == LAST) begin
            state       <= REDIRECT;
            flush       <= 1'b0;
            pc_redirect <= 1'b1;
            redirect_pc <= TRAP_VECTOR;
            mode        <= KERNEL_MODE;
          end else cnt <= cnt + 4'd1;
        end
        REDIRECT: begin
          state       <= HANDLER;
          stall       <= 1'b0;
          pc_redirect <= 1'b0;
          trap_active <= 1'b1;
        end
        HANDLER: begin
          if (fault) begin
            state       <= HALT;
            trap_active <= 1'b0;
            stall       <= 1'b1;
            halted      <= 1'b1;
          end else if (eret) begin
            state       <= RETURN;
            trap_active <= 1'b0;
            pc_redirect <= 1'b1;
            redirect_pc <= epc;
            flush       <= 1'b1;
            mode        <= saved_mode;
            cause       <= 2'b00;
          end else if (mode_we) mode <= mode_wdata;
        end
        RETURN: begin
          state       <= IDLE;
          pc_redirect <= 1'b0;
          flush       <= 1'b0;
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_fault_sequencer.sv
// tb_mem_fault_sequencer: table-driven and scoreboarded check of the trap sequencer
module tb_mem_fault_sequencer;
  typedef struct packed {
    logic        rst_n;
    logic        ipc;
    logic        imem;
    logic [15:0] pc;
    logic [15:0] fa;
    logic        eret;
    logic        we;
    logic [1:0]  wd;
  } in_t;
  typedef struct packed {
    logic [1:0]  mode;
    logic        stall;
    logic        flush;
    logic        pr;
    logic [15:0] rpc;
    logic [15:0] epc;
    logic [1:0]  cause;
    logic [15:0] bad;
    logic        trap;
    logic        halt;
  } out_t;
  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, illegal_pc, illegal_mem, eret, mode_we;
  logic [15:0] cur_pc, fault_addr;
  logic [1:0]  mode_wdata;
  logic [1:0]  mode, cause;
  logic        stall, flush, pc_redirect, trap_active, halted;
  logic [15:0] redirect_pc, epc, bad_addr;
  int checks = 0;
  int errors = 0;
  out_t exp_q[$];
  vec_t vecs[11];

  mem_fault_sequencer dut (
    .clk(clk), .rst_n(rst_n), .illegal_pc(illegal_pc), .illegal_mem(illegal_mem),
    .cur_pc(cur_pc), .fault_addr(fault_addr), .eret(eret), .mode_we(mode_we),
    .mode_wdata(mode_wdata), .mode(mode), .stall(stall), .flush(flush),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .epc(epc), .cause(cause),
    .bad_addr(bad_addr), .trap_active(trap_active), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic in_t mk_i(logic r, logic ip, logic im, logic [15:0] pc, logic [15:0] fa,
                               logic er, logic we, logic [1:0] wd);
    return '{rst_n: r, ipc: ip, imem: im, pc: pc, fa: fa, eret: er, we: we, wd: wd};
  endfunction

  function automatic out_t mk_o(logic [1:0] m, logic s, logic f, logic p, logic [15:0] r,
                                logic [15:0] e, logic [1:0] c, logic [15:0] b, logic t, logic h);
    return '{mode: m, stall: s, flush: f, pr: p, rpc: r, epc: e, cause: c, bad: b, trap: t, halt: h};
  endfunction

  task automatic step(input in_t i, input out_t o, input string name);
    out_t got, want;
    @(negedge clk);
    rst_n = i.rst_n; illegal_pc = i.ipc; illegal_mem = i.imem; cur_pc = i.pc;
    fault_addr = i.fa; eret = i.eret; mode_we = i.we; mode_wdata = i.wd;
    exp_q.push_back(o);
    @(posedge clk);
    #1;
    got = '{mode: mode, stall: stall, flush: flush, pr: pc_redirect, rpc: redirect_pc,
            epc: epc, cause: cause, bad: bad_addr, trap: trap_active, halt: halted};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got mode=%h st=%b fl=%b pr=%b rpc=%h epc=%h cause=%h bad=%h trap=%b halt=%b, want mode=%h st=%b fl=%b pr=%b rpc=%h epc=%h cause=%h bad=%h trap=%b halt=%b",
               name, got.mode, got.stall, got.flush, got.pr, got.rpc, got.epc, got.cause, got.bad,
               got.trap, got.halt, want.mode, want.stall, want.flush, want.pr, want.rpc, want.epc,
               want.cause, want.bad, want.trap, want.halt);
    end
  endtask

  initial begin
    rst_n = 1'b0; illegal_pc = 1'b0; illegal_mem = 1'b0; cur_pc = '0; fault_addr = '0;
    eret = 1'b0; mode_we = 1'b0; mode_wdata = '0;
    vecs[0]  = '{mk_i(0,0,0,16'h0,16'h0,0,0,2'd0), mk_o(2'b10,0,0,0,16'h0,16'h0,2'd0,16'h0,0,0)};
    vecs[1]  = '{mk_i(0,1,1,16'h1234,16'h5678,1,1,2'd1), mk_o(2'b10,0,0,0,16'h0,16'h0,2'd0,16'h0,0,0)};
    vecs[2]  = '{mk_i(1,0,0,16'h0,16'h0,0,1,2'd0), mk_o(2'b00,0,0,0,16'h0,16'h0,2'd0,16'h0,0,0)};
    vecs[3]  = '{mk_i(1,0,1,16'h0420,16'h0080,0,0,2'd0), mk_o(2'b00,1,1,0,16'h0,16'h0420,2'd2,16'h0080,0,0)};
    vecs[4]  = '{mk_i(1,1,1,16'h0999,16'h0999,1,1,2'd1), mk_o(2'b00,1,1,0,16'h0,16'h0420,2'd2,16'h0080,0,0)};
    vecs[5]  = '{mk_i(1,0,0,16'h0,16'h0,0,0,2'd0), mk_o(2'b10,1,0,1,16'h0010,16'h0420,2'd2,16'h0080,0,0)};
    vecs[6]  = '{mk_i(1,0,0,16'h0,16'h0,1,1,2'd3), mk_o(2'b10,0,0,0,16'h0010,16'h0420,2'd2,16'h0080,1,0)};
    vecs[7]  = '{mk_i(1,0,0,16'h0,16'h0,0,1,2'd3), mk_o(2'b11,0,0,0,16'h0010,16'h0420,2'd2,16'h0080,1,0)};
    vecs[8]  = '{mk_i(1,0,0,16'h0,16'h0,1,0,2'd0), mk_o(2'b00,0,1,1,16'h0420,16'h0420,2'd0,16'h0080,0,0)};
    vecs[9]  = '{mk_i(1,0,0,16'h0,16'h0,0,1,2'd1), mk_o(2'b00,0,0,0,16'h0420,16'h0420,2'd0,16'h0080,0,0)};
    vecs[10] = '{mk_i(1,0,0,16'h0,16'h0,1,0,2'd0), mk_o(2'b00,0,0,0,16'h0420,16'h0420,2'd0,16'h0080,0,0)};
    for (int k = 0; k < 11; k++) step(vecs[k].i, vecs[k].o, $sformatf("vec%0d", k));
    // both faults at once: illegal_pc wins, bad_addr untouched
    step(mk_i(1,1,1,16'h0050,16'h0099,0,0,2'd0), mk_o(2'b00,1,1,0,16'h0420,16'h0050,2'd1,16'h0080,0,0), "dual_fault");
    step(mk_i(1,0,0,16'h0,16'h0,0,0,2'd0), mk_o(2'b00,1,1,0,16'h0420,16'h0050,2'd1,16'h0080,0,0), "dual_flush2");
    step(mk_i(1,0,0,16'h0,16'h0,0,0,2'd0), mk_o(2'b10,1,0,1,16'h0010,16'h0050,2'd1,16'h0080,0,0), "dual_redirect");
    step(mk_i(1,0,0,16'h0,16'h0,0,0,2'd0), mk_o(2'b10,0,0,0,16'h0010,16'h0050,2'd1,16'h0080,1,0), "dual_handler");
    // fault with eret inside the handler halts
    step(mk_i(1,0,1,16'h0060,16'h0777,1,0,2'd0), mk_o(2'b10,1,0,0,16'h0010,16'h0050,2'd1,16'h0080,0,1), "halt_enter");
    step(mk_i(1,0,0,16'h0,16'h0,1,1,2'd1), mk_o(2'b10,1,0,0,16'h0010,16'h0050,2'd1,16'h0080,0,1), "halt_eret");
    step(mk_i(1,1,1,16'h0070,16'h0070,0,1,2'd0), mk_o(2'b10,1,0,0,16'h0010,16'h0050,2'd1,16'h0080,0,1), "halt_fault");
    step(mk_i(0,0,0,16'h0,16'h0,0,0,2'd0), mk_o(2'b10,0,0,0,16'h0,16'h0,2'd0,16'h0,0,0), "halt_reset");
    // mode write dropped when a fault arrives in the same cycle
    step(mk_i(1,0,0,16'h0,16'h0,0,1,2'd0), mk_o(2'b00,0,0,0,16'h0,16'h0,2'd0,16'h0,0,0), "we_set00");
    step(mk_i(1,1,0,16'h0077,16'h0123,0,1,2'd1), mk_o(2'b00,1,1,0,16'h0,16'h0077,2'd1,16'h0,0,0), "we_drop");
    step(mk_i(1,0,0,16'h0,16'h0,0,0,2'd0), mk_o(2'b00,1,1,0,16'h0,16'h0077,2'd1,16'h0,0,0), "we_flush2");
    step(mk_i(1,0,0,16'h0,16'h0,0,0,2'd0), mk_o(2'b10,1,0,1,16'h0010,16'h0077,2'd1,16'h0,0,0), "we_redirect");
    step(mk_i(1,0,0,16'h0,16'h0,0,0,2'd0), mk_o(2'b10,0,0,0,16'h0010,16'h0077,2'd1,16'h0,1,0), "we_handler");
    step(mk_i(1,0,0,16'h0,16'h0,1,0,2'd0), mk_o(2'b00,0,1,1,16'h0077,16'h0077,2'd0,16'h0,0,0), "we_return");
    step(mk_i(1,0,0,16'h0,16'h0,0,0,2'd0), mk_o(2'b00,0,0,0,16'h0077,16'h0077,2'd0,16'h0,0,0), "we_idle");
    // reset in the middle of a flush issues no redirect
    step(mk_i(1,0,1,16'h0300,16'h0400,0,0,2'd0), mk_o(2'b00,1,1,0,16'h0077,16'h0300,2'd2,16'h0400,0,0), "mid_fault");
    step(mk_i(0,0,0,16'h0,16'h0,0,0,2'd0), mk_o(2'b10,0,0,0,16'h0,16'h0,2'd0,16'h0,0,0), "mid_reset");
    step(mk_i(1,0,0,16'h0,16'h0,0,0,2'd0), mk_o(2'b10,0,0,0,16'h0,16'h0,2'd0,16'h0,0,0), "mid_after");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
